// File: rtl/micro_seq_pkg.sv
// micro_seq_pkg: shared definitions for the microprogram sequencer.
// Provides the next-address operation encodings, default widths and the
// condition channel indices used by the control register fields.
package micro_seq_pkg;

  // Default microaddress width and condition channel count
  localparam int DEFAULT_UADDR_W = 7;
  localparam int DEFAULT_NCOND   = 4;

  // Condition channel indices as wired by the control unit
  localparam int COND_MOC  = 0;
  localparam int COND_COND = 1;
  localparam int COND_DMOC = 2;

  // Next-address operation carried by each microinstruction
  typedef enum logic [2:0] {
    OP_INC   = 3'b000,
    OP_JMP   = 3'b001,
    OP_DEC   = 3'b010,
    OP_FETCH = 3'b011,
    OP_CJMP  = 3'b100,
    OP_CWAIT = 3'b101,
    OP_CALL  = 3'b110,
    OP_RET   = 3'b111
  } next_op_e;

endpackage

// File: rtl/micro_return_stack.sv
// micro_return_stack: small LIFO holding microsubroutine return addresses.
// A push while full or a pop while empty is ignored here; the sequencer
// turns those attempts into its sticky error flags.
module micro_return_stack #(
  parameter int DEPTH = 4,
  parameter int WIDTH = 7
) (
  input  logic                       clk,
  input  logic                       reset,
  input  logic                       push,
  input  logic                       pop,
  input  logic [WIDTH-1:0]           push_data,
  output logic [WIDTH-1:0]           top,
  output logic [$clog2(DEPTH+1)-1:0] count,
  output logic                       full,
  output logic                       empty
);

  localparam int CNT_W = $clog2(DEPTH + 1);
  localparam int IDX_W = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [WIDTH-1:0] mem [DEPTH];
  logic [IDX_W-1:0] wr_idx;
  logic [IDX_W-1:0] top_idx;

  assign full    = (count == CNT_W'(DEPTH));
  assign empty   = (count == '0);
  assign wr_idx  = IDX_W'(count);
  assign top_idx = IDX_W'(count - CNT_W'(1));
  assign top     = empty ? '0 : mem[top_idx];

  // Occupancy counter; reset empties the stack regardless of contents
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      count <= '0;
    end else if (push && !full) begin
      count <= count + CNT_W'(1);
    end else if (pop && !empty) begin
      count <= count - CNT_W'(1);
    end
  end

  // Entry storage; contents above count are don't-care so no reset needed
  always_ff @(posedge clk) begin
    if (push && !full) begin
      mem[wr_idx] <= push_data;
    end
  end

endmodule

// File: rtl/micro_sequencer.sv
// micro_sequencer: next-microaddress generator for the microprogrammed
// control unit. Picks the next state from increment, branch target,
// decoded entry, fetch address, conditional wait or the return stack.
// Optional wait timeout is enabled with `define MICRO_SEQ_WAIT_TIMEOUT_EN.
module micro_sequencer
  import micro_seq_pkg::*;
#(
  parameter int          UADDR_W        = DEFAULT_UADDR_W,
  parameter int          NCOND          = DEFAULT_NCOND,
  parameter int          STACK_DEPTH    = 4,
  parameter int unsigned RESET_ADDR     = 0,
  parameter int unsigned FETCH_ADDR     = 1,
  parameter int unsigned TIMEOUT_CYCLES = 255
) (
  input  logic                             clk,
  input  logic                             reset,
  input  logic                             hold,
  input  logic [NCOND-1:0]                 cond_in,
  input  logic [$clog2(NCOND)-1:0]         cond_sel,
  input  logic                             cond_inv,
  input  logic [2:0]                       next_op,
  input  logic [UADDR_W-1:0]               target,
  input  logic [UADDR_W-1:0]               decode_addr,
  output logic [UADDR_W-1:0]               uaddr,
  output logic [$clog2(STACK_DEPTH+1)-1:0] stack_cnt,
  output logic                             err_ovf,
  output logic                             err_unf,
  output logic                             wait_timeout
);

  localparam int SEL_W = $clog2(NCOND);
  localparam logic [UADDR_W-1:0] RESET_UA = UADDR_W'(RESET_ADDR);
  localparam logic [UADDR_W-1:0] FETCH_UA = UADDR_W'(FETCH_ADDR);
  localparam logic [SEL_W:0]     NCOND_L  = (SEL_W + 1)'(NCOND);

  // Reject parameter sets the sequencer cannot support
  if (NCOND < 2 || STACK_DEPTH < 1 || TIMEOUT_CYCLES < 1) begin : g_param_check
    $error("micro_sequencer: NCOND>=2, STACK_DEPTH>=1, TIMEOUT_CYCLES>=1 required");
  end

  logic               cond_raw;
  logic               cond_val;
  logic [UADDR_W-1:0] inc_addr;
  logic [UADDR_W-1:0] next_addr;
  logic [UADDR_W-1:0] seq_addr;
  logic [UADDR_W-1:0] stack_top;
  logic               push_req;
  logic               pop_req;
  logic               set_ovf;
  logic               set_unf;
  logic               wait_stall;
  logic               stack_full;
  logic               stack_empty;

  assign inc_addr = uaddr + UADDR_W'(1);
  assign cond_val = cond_raw ^ cond_inv;

  // Selected condition channel; selectors beyond the last channel read 0
  always_comb begin
    cond_raw = 1'b0;
    if ({1'b0, cond_sel} < NCOND_L) begin
      cond_raw = cond_in[cond_sel];
    end
  end

  // Next-address selection and stack requests for the current microinstruction
  always_comb begin
    next_addr  = uaddr;
    push_req   = 1'b0;
    pop_req    = 1'b0;
    set_ovf    = 1'b0;
    set_unf    = 1'b0;
    wait_stall = 1'b0;
    case (next_op)
      OP_INC:   next_addr = inc_addr;
      OP_JMP:   next_addr = target;
      OP_DEC:   next_addr = decode_addr;
      OP_FETCH: next_addr = FETCH_UA;
      OP_CJMP:  next_addr = cond_val ? target : inc_addr;
      OP_CWAIT: begin
        if (cond_val) begin
          next_addr = inc_addr;
        end else begin
          wait_stall = 1'b1;
        end
      end
      OP_CALL: begin
        next_addr = target;
        if (stack_full) begin
          set_ovf = 1'b1;
        end else begin
          push_req = 1'b1;
        end
      end
      OP_RET: begin
        if (stack_empty) begin
          set_unf   = 1'b1;
          next_addr = FETCH_UA;
        end else begin
          next_addr = stack_top;
          pop_req   = 1'b1;
        end
      end
      default: next_addr = uaddr;
    endcase
  end

`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
  localparam int TO_W = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TO_W-1:0] TO_LAST = TO_W'(TIMEOUT_CYCLES - 1);

  logic [TO_W-1:0] wait_cnt;
  logic            timeout_hit;

  assign timeout_hit = wait_stall && (wait_cnt == TO_LAST);
  assign seq_addr    = timeout_hit ? target : next_addr;

  // Wait counter: counts stalled CWAIT cycles and fires the timeout pulse
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wait_cnt     <= '0;
      wait_timeout <= 1'b0;
    end else if (hold) begin
      wait_timeout <= 1'b0;
    end else if (timeout_hit) begin
      wait_cnt     <= '0;
      wait_timeout <= 1'b1;
    end else if (wait_stall) begin
      wait_cnt     <= wait_cnt + TO_W'(1);
      wait_timeout <= 1'b0;
    end else begin
      wait_cnt     <= '0;
      wait_timeout <= 1'b0;
    end
  end
`else
  assign seq_addr     = next_addr;
  assign wait_timeout = 1'b0;
`endif

  // Current microaddress and sticky stack error flags
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      uaddr   <= RESET_UA;
      err_ovf <= 1'b0;
      err_unf <= 1'b0;
    end else if (!hold) begin
      uaddr <= seq_addr;
      if (set_ovf) begin
        err_ovf <= 1'b1;
      end
      if (set_unf) begin
        err_unf <= 1'b1;
      end
    end
  end

  micro_return_stack #(
    .DEPTH (STACK_DEPTH),
    .WIDTH (UADDR_W)
  ) u_stack (
    .clk       (clk),
    .reset     (reset),
    .push      (push_req && !hold),
    .pop       (pop_req && !hold),
    .push_data (inc_addr),
    .top       (stack_top),
    .count     (stack_cnt),
    .full      (stack_full),
    .empty     (stack_empty)
  );

endmodule

// File: tb/tb_micro_sequencer.sv
// tb_micro_sequencer: self-checking bench for micro_sequencer.
// Table vectors and directed sequences use fixed expected values; the
// random phase compares against a queue-based reference model.
module tb_micro_sequencer;
  import micro_seq_pkg::*;

  localparam int UADDR_W        = 7;
  localparam int NCOND          = 4;
  localparam int STACK_DEPTH    = 4;
  localparam int RESET_ADDR     = 0;
  localparam int FETCH_ADDR     = 1;
  localparam int TIMEOUT_CYCLES = 8;

  logic               clk = 1'b0;
  logic               reset = 1'b0;
  logic               hold = 1'b0;
  logic [3:0]         cond_in = '0;
  logic [1:0]         cond_sel = '0;
  logic               cond_inv = 1'b0;
  logic [2:0]         next_op = '0;
  logic [UADDR_W-1:0] target = '0;
  logic [UADDR_W-1:0] decode_addr = '0;
  logic [UADDR_W-1:0] uaddr;
  logic [2:0]         stack_cnt;
  logic               err_ovf;
  logic               err_unf;
  logic               wait_timeout;

  int compared = 0;
  int mismatched = 0;

  int m_uaddr;
  int m_stack[$];
  bit m_ovf;
  bit m_unf;
  bit m_timeout;
  int m_wait;

  typedef struct {
    logic [2:0] op;
    logic [6:0] tgt;
    logic [6:0] dec;
    logic [3:0] cin;
    logic [1:0] sel;
    logic       inv;
    logic       hld;
    logic [6:0] exp_ua;
    logic [2:0] exp_cnt;
  } vec_t;

  vec_t vecs[$];

  micro_sequencer #(
    .UADDR_W        (UADDR_W),
    .NCOND          (NCOND),
    .STACK_DEPTH    (STACK_DEPTH),
    .RESET_ADDR     (RESET_ADDR),
    .FETCH_ADDR     (FETCH_ADDR),
    .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
  ) dut (
    .clk          (clk),
    .reset        (reset),
    .hold         (hold),
    .cond_in      (cond_in),
    .cond_sel     (cond_sel),
    .cond_inv     (cond_inv),
    .next_op      (next_op),
    .target       (target),
    .decode_addr  (decode_addr),
    .uaddr        (uaddr),
    .stack_cnt    (stack_cnt),
    .err_ovf      (err_ovf),
    .err_unf      (err_unf),
    .wait_timeout (wait_timeout)
  );

  // Free-running clock, rising edges at 5, 15, 25 ...
  always #5 clk = ~clk;

  task automatic check_output(input string name, input logic [31:0] actual,
                              input logic [31:0] expected);
    compared++;
    if (actual !== expected) begin
      mismatched++;
      $display("[TB] FAIL %s: got %0d, expected %0d", name, actual, expected);
    end
  endtask

  task automatic model_reset();
    m_uaddr = RESET_ADDR;
    m_stack.delete();
    m_ovf = 1'b0;
    m_unf = 1'b0;
    m_timeout = 1'b0;
    m_wait = 0;
  endtask

  // Reference behaviour for one clock edge, written from the operation rules
  task automatic model_step();
    int  c;
    int  inc_v;
    int  nxt;
    bit  leave;
    if (hold) begin
      m_timeout = 1'b0;
      return;
    end
    c = int'(cond_in[cond_sel] ^ cond_inv);
    inc_v = (m_uaddr + 1) % (1 << UADDR_W);
    nxt = m_uaddr;
    leave = 1'b1;
    m_timeout = 1'b0;
    case (next_op)
      3'd0: nxt = inc_v;
      3'd1: nxt = int'(target);
      3'd2: nxt = int'(decode_addr);
      3'd3: nxt = FETCH_ADDR;
      3'd4: nxt = (c != 0) ? int'(target) : inc_v;
      3'd5: begin
        if (c != 0) begin
          nxt = inc_v;
        end else begin
`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
          leave = 1'b0;
          m_wait++;
          if (m_wait >= TIMEOUT_CYCLES) begin
            nxt = int'(target);
            m_timeout = 1'b1;
            m_wait = 0;
          end
`endif
        end
      end
      3'd6: begin
        if (m_stack.size() < STACK_DEPTH) m_stack.push_back(inc_v);
        else m_ovf = 1'b1;
        nxt = int'(target);
      end
      default: begin
        if (m_stack.size() > 0) begin
          nxt = m_stack.pop_back();
        end else begin
          m_unf = 1'b1;
          nxt = FETCH_ADDR;
        end
      end
    endcase
    if (leave) m_wait = 0;
    m_uaddr = nxt;
  endtask

  // Drive one microinstruction, advance the model, then sample after the edge
  task automatic apply_stimulus(input logic [2:0] op, input logic [6:0] tgt,
                                input logic [6:0] dec, input logic [3:0] cin,
                                input logic [1:0] sel, input logic inv,
                                input logic hld);
    next_op = op;
    target = tgt;
    decode_addr = dec;
    cond_in = cin;
    cond_sel = sel;
    cond_inv = inv;
    hold = hld;
    model_step();
    @(posedge clk);
    #1;
  endtask

  task automatic check_model(input string tag);
    check_output({tag, " uaddr"}, 32'(uaddr), 32'(m_uaddr));
    check_output({tag, " stack_cnt"}, 32'(stack_cnt), 32'(m_stack.size()));
    check_output({tag, " err_ovf"}, 32'(err_ovf), 32'(m_ovf));
    check_output({tag, " err_unf"}, 32'(err_unf), 32'(m_unf));
    check_output({tag, " wait_timeout"}, 32'(wait_timeout), 32'(m_timeout));
  endtask

  task automatic do_reset();
    reset = 1'b0;
    hold = 1'b0;
    next_op = OP_INC;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_output("reset uaddr", 32'(uaddr), RESET_ADDR);
    check_output("reset stack_cnt", 32'(stack_cnt), 0);
    check_output("reset err_ovf", 32'(err_ovf), 0);
    check_output("reset err_unf", 32'(err_unf), 0);
    check_output("reset wait_timeout", 32'(wait_timeout), 0);
    reset = 1'b1;
  endtask

  initial begin
    $display("[TB] micro_sequencer bench start");
    #1;
    check_output("async reset uaddr", 32'(uaddr), RESET_ADDR);
    do_reset();

    // op, target, decode, cond_in, sel, inv, hold, expected uaddr, expected count
    vecs.push_back('{OP_INC,   7'd0,   7'd0,  4'b0000, 2'd0, 1'b0, 1'b0, 7'd1,   3'd0});
    vecs.push_back('{OP_INC,   7'd0,   7'd0,  4'b0000, 2'd0, 1'b0, 1'b0, 7'd2,   3'd0});
    vecs.push_back('{OP_INC,   7'd0,   7'd0,  4'b0000, 2'd0, 1'b0, 1'b0, 7'd3,   3'd0});
    vecs.push_back('{OP_JMP,   7'd5,   7'd0,  4'b0000, 2'd0, 1'b0, 1'b0, 7'd5,   3'd0});
    vecs.push_back('{OP_CALL,  7'd40,  7'd0,  4'b0000, 2'd0, 1'b0, 1'b0, 7'd40,  3'd1});
    vecs.push_back('{OP_RET,   7'd0,   7'd0,  4'b0000, 2'd0, 1'b0, 1'b0, 7'd6,   3'd0});
    vecs.push_back('{OP_DEC,   7'd0,   7'd23, 4'b0000, 2'd0, 1'b0, 1'b0, 7'd23,  3'd0});
    vecs.push_back('{OP_JMP,   7'd50,  7'd0,  4'b0000, 2'd0, 1'b0, 1'b1, 7'd23,  3'd0});
    vecs.push_back('{OP_CJMP,  7'd60,  7'd0,  4'b0010, 2'd1, 1'b0, 1'b0, 7'd60,  3'd0});
    vecs.push_back('{OP_CJMP,  7'd60,  7'd0,  4'b0000, 2'd1, 1'b0, 1'b0, 7'd61,  3'd0});
    vecs.push_back('{OP_CJMP,  7'd70,  7'd0,  4'b0000, 2'd1, 1'b1, 1'b0, 7'd70,  3'd0});
    vecs.push_back('{OP_CJMP,  7'd90,  7'd0,  4'b0100, 2'd2, 1'b1, 1'b0, 7'd71,  3'd0});
    vecs.push_back('{OP_FETCH, 7'd0,   7'd0,  4'b0000, 2'd0, 1'b0, 1'b0, 7'd1,   3'd0});
    vecs.push_back('{OP_JMP,   7'd127, 7'd0,  4'b0000, 2'd0, 1'b0, 1'b0, 7'd127, 3'd0});
    vecs.push_back('{OP_INC,   7'd0,   7'd0,  4'b0000, 2'd0, 1'b0, 1'b0, 7'd0,   3'd0});

    foreach (vecs[i]) begin
      apply_stimulus(vecs[i].op, vecs[i].tgt, vecs[i].dec, vecs[i].cin,
                     vecs[i].sel, vecs[i].inv, vecs[i].hld);
      check_output($sformatf("vec%0d uaddr", i), 32'(uaddr), 32'(vecs[i].exp_ua));
      check_output($sformatf("vec%0d stack_cnt", i), 32'(stack_cnt), 32'(vecs[i].exp_cnt));
      check_output($sformatf("vec%0d err_ovf", i), 32'(err_ovf), 0);
    end

    // Handshake wait on MOC, then the same wait with inverted sense
    apply_stimulus(OP_JMP, 7'd10, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(OP_CWAIT, 7'd99, 7'd0, 4'b0000, COND_MOC[1:0], 1'b0, 1'b0);
      check_output($sformatf("cwait stall%0d uaddr", i), 32'(uaddr), 10);
    end
    apply_stimulus(OP_CWAIT, 7'd99, 7'd0, 4'b0001, COND_MOC[1:0], 1'b0, 1'b0);
    check_output("cwait release uaddr", 32'(uaddr), 11);
    for (int i = 0; i < 2; i++) begin
      apply_stimulus(OP_CWAIT, 7'd99, 7'd0, 4'b0001, COND_MOC[1:0], 1'b1, 1'b0);
      check_output($sformatf("cwait inv stall%0d uaddr", i), 32'(uaddr), 11);
    end
    apply_stimulus(OP_CWAIT, 7'd99, 7'd0, 4'b0000, COND_MOC[1:0], 1'b1, 1'b0);
    check_output("cwait inv release uaddr", 32'(uaddr), 12);

    // Nested calls to full depth, one overflowing call, then unwinding
    apply_stimulus(OP_JMP, 7'd10, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(OP_CALL, 7'(20 + 10 * i), 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
      check_output($sformatf("call%0d uaddr", i), 32'(uaddr), 20 + 10 * i);
      check_output($sformatf("call%0d stack_cnt", i), 32'(stack_cnt), i + 1);
      check_output($sformatf("call%0d err_ovf", i), 32'(err_ovf), 0);
    end
    apply_stimulus(OP_CALL, 7'd60, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
    check_output("overflow uaddr", 32'(uaddr), 60);
    check_output("overflow err_ovf", 32'(err_ovf), 1);
    check_output("overflow stack_cnt", 32'(stack_cnt), 4);
    for (int i = 0; i < 4; i++) begin
      apply_stimulus(OP_RET, 7'd0, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
      check_output($sformatf("ret%0d uaddr", i), 32'(uaddr), 41 - 10 * i);
      check_output($sformatf("ret%0d stack_cnt", i), 32'(stack_cnt), 3 - i);
    end
    apply_stimulus(OP_RET, 7'd0, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
    check_output("underflow uaddr", 32'(uaddr), FETCH_ADDR);
    check_output("underflow err_unf", 32'(err_unf), 1);
    check_output("underflow stack_cnt", 32'(stack_cnt), 0);
    apply_stimulus(OP_INC, 7'd0, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
    check_output("sticky err_ovf", 32'(err_ovf), 1);
    check_output("sticky err_unf", 32'(err_unf), 1);
    apply_stimulus(OP_CALL, 7'd33, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
    check_output("post-error call uaddr", 32'(uaddr), 33);
    check_output("post-error call stack_cnt", 32'(stack_cnt), 1);
    apply_stimulus(OP_RET, 7'd0, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b1);
    check_output("held ret uaddr", 32'(uaddr), 33);
    check_output("held ret stack_cnt", 32'(stack_cnt), 1);

    // Reset asserted while held acts immediately, between clock edges
    next_op = OP_JMP;
    target = 7'd50;
    hold = 1'b1;
    #2;
    reset = 1'b0;
    model_reset();
    #1;
    check_output("hold-reset uaddr", 32'(uaddr), RESET_ADDR);
    check_output("hold-reset stack_cnt", 32'(stack_cnt), 0);
    check_output("hold-reset err_ovf", 32'(err_ovf), 0);
    check_output("hold-reset err_unf", 32'(err_unf), 0);
    @(posedge clk);
    #1;
    reset = 1'b1;
    hold = 1'b0;

    // Wait timeout, including the counter clearing when a wait is left
    apply_stimulus(OP_JMP, 7'd10, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
`ifdef MICRO_SEQ_WAIT_TIMEOUT_EN
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
      apply_stimulus(OP_CWAIT, 7'd99, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
      check_output($sformatf("to wait%0d uaddr", i), 32'(uaddr), 10);
      check_output($sformatf("to wait%0d wait_timeout", i), 32'(wait_timeout), 0);
    end
    apply_stimulus(OP_CWAIT, 7'd99, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
    check_output("timeout uaddr", 32'(uaddr), 99);
    check_output("timeout pulse", 32'(wait_timeout), 1);
    apply_stimulus(OP_INC, 7'd0, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
    check_output("after timeout uaddr", 32'(uaddr), 100);
    check_output("after timeout pulse", 32'(wait_timeout), 0);
    apply_stimulus(OP_JMP, 7'd10, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
    for (int i = 0; i < 5; i++) begin
      apply_stimulus(OP_CWAIT, 7'd99, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
    end
    apply_stimulus(OP_CWAIT, 7'd99, 7'd0, 4'b0001, 2'd0, 1'b0, 1'b0);
    check_output("to leave uaddr", 32'(uaddr), 11);
    for (int i = 0; i < TIMEOUT_CYCLES - 1; i++) begin
      apply_stimulus(OP_CWAIT, 7'd99, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
      check_output($sformatf("to rewait%0d uaddr", i), 32'(uaddr), 11);
    end
    apply_stimulus(OP_CWAIT, 7'd99, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
    check_output("retimeout uaddr", 32'(uaddr), 99);
`else
    for (int i = 0; i < 3 * TIMEOUT_CYCLES; i++) begin
      apply_stimulus(OP_CWAIT, 7'd99, 7'd0, 4'b0000, 2'd0, 1'b0, 1'b0);
      check_output($sformatf("no-to wait%0d uaddr", i), 32'(uaddr), 10);
      check_output($sformatf("no-to wait%0d wait_timeout", i), 32'(wait_timeout), 0);
    end
`endif

    // Randomised microinstruction stream against the reference model
    do_reset();
    for (int i = 0; i < 800; i++) begin
      if (i == 400) do_reset();
      apply_stimulus(3'($urandom_range(0, 7)), 7'($urandom), 7'($urandom),
                     4'($urandom), 2'($urandom), 1'($urandom_range(0, 3) == 0),
                     1'($urandom_range(0, 7) == 0));
      check_model($sformatf("rand%0d", i));
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
